hs_arith_pipe_multi_in_adder: RTL and testbench

Pipelined, flow-controlled multi-input adder: sums INPUT_NUM operands of DATA_WIDTH bits through a balanced binary adder tree with programmable register density, in unsigned or two's-complement mode. Unlike the combinational multi-input adder, it accepts any INPUT_NUM (not only powers of two). It carries a valid/ready handshake through every register stage, so any stage stalls independently under downstream backpressure at full throughput. It sits in datapaths (popcount, dot-product reduction, filter taps) where the tree is too deep for one cycle.

---
 rtl/hs_arith_pipe_multi_in_adder.sv | 126 ++++++++++++
 tb/tb_hs_arith_pipe_multi_in_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hs_arith_pipe_multi_in_adder.sv
`default_nettype none
// ============================================================================
// hs_arith_pipe_multi_in_adder: pipelined valid/ready adder tree over INPUT_NUM operands
// Revision: 1.0
// ============================================================================
module hs_arith_pipe_multi_in_adder #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUT_NUM  = 16,
  parameter int SIGNED     = 0,
  parameter int REG_STRIDE = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        din_valid,
  output logic                                        din_ready,
  input  logic [DATA_WIDTH-1:0]                       din [INPUT_NUM],
  output logic                                        dout_valid,
  input  logic                                        dout_ready,
  output logic [DATA_WIDTH+$clog2(INPUT_NUM)-1:0]     dout
);

  localparam int ADD_LEVELS   = $clog2(INPUT_NUM);
  localparam int PIPE_STAGES  = (ADD_LEVELS + REG_STRIDE - 1) / REG_STRIDE;
  localparam int OUTPUT_WIDTH = DATA_WIDTH + $clog2(INPUT_NUM);

  typedef logic [INPUT_NUM-1:0][OUTPUT_WIDTH-1:0] vec_t;

  // Number of live elements entering tree level 'level'.
  function automatic int count_at(input int level);
    int n;
    n = INPUT_NUM;
    for (int k = 0; k < ADD_LEVELS; k++) begin
      if (k < level) n = (n + 1) / 2;
    end
    return n;
  endfunction

  // One tree level: element i pairs with i+ceil(n/2); an odd middle element passes through.
  function automatic vec_t add_level(input vec_t e, input int n);
    vec_t r;
    int   h;
    r = '0;
    h = (n + 1) / 2;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (i < n / 2)  r[i] = e[i] + e[(i + h) % INPUT_NUM];
      else if (i < h) r[i] = e[i];
    end
    return r;
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] head(input vec_t e);
    return e[0];
  endfunction

  logic [PIPE_STAGES-1:0] valid_q;
  vec_t                   data_q [PIPE_STAGES];
  vec_t                   data_d [PIPE_STAGES];
  vec_t                   src    [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] up_valid;
  logic [PIPE_STAGES-1:0] stage_rdy;
  vec_t                   ext;

  always_comb begin
    ext = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (SIGNED != 0) ext[i] = OUTPUT_WIDTH'(signed'(din[i]));
      else             ext[i] = OUTPUT_WIDTH'(din[i]);
    end
  end

  always_comb begin
    src[0]      = ext;
    up_valid[0] = din_valid;
    for (int j = 1; j < PIPE_STAGES; j++) begin
      src[j]      = data_q[j-1];
      up_valid[j] = valid_q[j-1];
    end
  end

  // Stage j evaluates tree levels [j*REG_STRIDE, (j+1)*REG_STRIDE).
  always_comb begin : p_tree
    vec_t acc;
    acc = '0;
    for (int j = 0; j < PIPE_STAGES; j++) begin
      acc = src[j];
      for (int k = 0; k < ADD_LEVELS; k++) begin
        if (k / REG_STRIDE == j) acc = add_level(acc, count_at(k));
      end
      data_d[j] = acc;
    end
  end

  // Unrolled form of rdy[j] = !v[j] | rdy[j+1]: ready unless every stage from j down is full.
  always_comb begin : p_ready
    logic all_full;
    all_full  = 1'b0;
    stage_rdy = '0;
    for (int j = 0; j < PIPE_STAGES; j++) begin
      all_full = 1'b1;
      for (int m = 0; m < PIPE_STAGES; m++) begin
        if (m >= j) all_full = all_full & valid_q[m];
      end
      stage_rdy[j] = dout_ready | ~all_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int j = 0; j < PIPE_STAGES; j++) data_q[j] <= '0;
    end else begin
      for (int j = 0; j < PIPE_STAGES; j++) begin
        if (stage_rdy[j]) begin
          valid_q[j] <= up_valid[j];
          if (up_valid[j]) data_q[j] <= data_d[j];
        end
      end
    end
  end

  assign din_ready  = rst_n & stage_rdy[0];
  assign dout_valid = valid_q[PIPE_STAGES-1];
  assign dout       = head(data_q[PIPE_STAGES-1]);

endmodule
`default_nettype wire

// File: tb/tb_hs_arith_pipe_multi_in_adder.sv
`default_nettype none
// ============================================================================
// tb_hs_arith_pipe_multi_in_adder: randomized and directed checks against a sum/queue model
// Revision: 1.0
// ============================================================================
module tb_hs_arith_pipe_multi_in_adder;

  localparam int NSETS = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT a: 8-bit x 16 unsigned, one level per stage (4 stages)
  logic        a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic [7:0]  a_din [16];
  logic [11:0] a_dout;
  // DUT b: 4-bit x 5 signed, two levels per stage (2 stages)
  logic        b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic [3:0]  b_din [5];
  logic [6:0]  b_dout;
  // DUT c: 1-bit x 128 unsigned (7 stages)
  logic        c_din_valid, c_din_ready, c_dout_valid, c_dout_ready;
  logic [0:0]  c_din [128];
  logic [7:0]  c_dout;

  hs_arith_pipe_multi_in_adder #(.DATA_WIDTH(8), .INPUT_NUM(16), .SIGNED(0), .REG_STRIDE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .din_valid(a_din_valid), .din_ready(a_din_ready), .din(a_din),
    .dout_valid(a_dout_valid), .dout_ready(a_dout_ready), .dout(a_dout));

  hs_arith_pipe_multi_in_adder #(.DATA_WIDTH(4), .INPUT_NUM(5), .SIGNED(1), .REG_STRIDE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din_valid(b_din_valid), .din_ready(b_din_ready), .din(b_din),
    .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .dout(b_dout));

  hs_arith_pipe_multi_in_adder #(.DATA_WIDTH(1), .INPUT_NUM(128), .SIGNED(0), .REG_STRIDE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .din_valid(c_din_valid), .din_ready(c_din_ready), .din(c_din),
    .dout_valid(c_dout_valid), .dout_ready(c_dout_ready), .dout(c_dout));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] a_model();
    int s;
    s = 0;
    foreach (a_din[i]) s += int'(a_din[i]);
    return 12'(s);
  endfunction

  function automatic logic [6:0] b_model();
    int s;
    s = 0;
    foreach (b_din[i]) s += int'($signed(b_din[i]));
    return 7'(s);
  endfunction

  initial begin
    logic [11:0] aq [$];
    bit          bv [$];
    logic [6:0]  bs [$];
    logic        prev_stall;
    logic [11:0] prev_dout;
    int          n, sent, got, cyc;

    a_din_valid = 0; a_dout_ready = 0; foreach (a_din[i]) a_din[i] = '0;
    b_din_valid = 0; b_dout_ready = 0; foreach (b_din[i]) b_din[i] = '0;
    c_din_valid = 0; c_dout_ready = 0; foreach (c_din[i]) c_din[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_din_ready_low", a_din_ready, 0);
    rst_n = 1;
    #1;
    check("rst_dout", a_dout, 0);
    check("rst_dout_valid", a_dout_valid, 0);
    check("rst_din_ready", a_din_ready, 1);

    // a: all 255 -> 4080 after 4 cycles
    @(negedge clk);
    a_dout_ready = 1; a_din_valid = 1;
    foreach (a_din[i]) a_din[i] = 8'hff;
    #1 check("a_lat_din_ready", a_din_ready, 1);
    @(negedge clk); a_din_valid = 0; n = 1;
    while (!a_dout_valid && n < 20) begin @(negedge clk); n++; end
    check("a_latency", n, 4);
    check("a_sum_255", a_dout, 4080);

    // b: {-8,7,-1,3,-8} -> -7
    b_dout_ready = 1; b_din_valid = 1;
    b_din[0] = 4'h8; b_din[1] = 4'h7; b_din[2] = 4'hf; b_din[3] = 4'h3; b_din[4] = 4'h8;
    @(negedge clk); b_din_valid = 0; n = 1;
    while (!b_dout_valid && n < 20) begin @(negedge clk); n++; end
    check("b_latency", n, 2);
    check("b_sum_signed", b_dout, 7'h79);

    // c: 128 ones -> 128, latency 7
    c_dout_ready = 1; c_din_valid = 1;
    foreach (c_din[i]) c_din[i] = 1'b1;
    @(negedge clk); c_din_valid = 0; n = 1;
    while (!c_dout_valid && n < 20) begin @(negedge clk); n++; end
    check("c_latency", n, 7);
    check("c_sum_ones", c_dout, 128);

    // b: 100 back-to-back random sets, one result per cycle at latency 2
    repeat (2) @(negedge clk);
    for (int k = 0; k < 104; k++) begin
      if (bv.size() == 2) begin
        bit         ev;
        logic [6:0] es;
        ev = bv.pop_front();
        es = bs.pop_front();
        check("b_stream_valid", b_dout_valid, ev);
        if (ev) check("b_stream_sum", b_dout, es);
      end else begin
        check("b_stream_idle", b_dout_valid, 0);
      end
      b_din_valid = (k < 100);
      foreach (b_din[i]) b_din[i] = 4'($urandom);
      #1 check("b_stream_ready", b_din_ready, 1);
      bv.push_back(b_din_valid);
      bs.push_back(b_model());
      @(negedge clk);
    end
    b_din_valid = 0;

    // a: random valid/ready, in-order, no loss/duplication, stability under stall
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_dout = '0;
    while (got < NSETS && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("a_hold_valid", a_dout_valid, 1);
        check("a_hold_data", a_dout, prev_dout);
      end
      a_dout_ready = 1'($urandom_range(0, 1));
      a_din_valid  = (sent < NSETS) && ($urandom_range(0, 1) == 1);
      foreach (a_din[i]) a_din[i] = 8'($urandom);
      #1;
      check("a_din_ready", a_din_ready, !(aq.size() == 4 && !a_dout_ready));
      if (a_dout_valid && a_dout_ready) begin
        if (aq.size() == 0) check("a_spurious_out", a_dout_valid, 0);
        else begin
          check("a_order_sum", a_dout, aq.pop_front());
          got++;
        end
      end
      if (a_din_valid && a_din_ready) begin
        aq.push_back(a_model());
        sent++;
      end
      prev_stall = a_dout_valid && !a_dout_ready;
      prev_dout  = a_dout;
    end
    check("a_set_count", got, NSETS);

    // a: fill with dout_ready=0, reset for one cycle, no stale sum afterwards
    @(negedge clk);
    a_dout_ready = 0; a_din_valid = 1;
    foreach (a_din[i]) a_din[i] = 8'h5a;
    repeat (6) @(negedge clk);
    a_din_valid = 0;
    #1;
    check("a_full_din_ready", a_din_ready, 0);
    check("a_full_dout_valid", a_dout_valid, 1);
    rst_n = 0;
    #1 check("a_rst_din_ready", a_din_ready, 0);
    @(negedge clk);
    check("a_rst_dout_valid", a_dout_valid, 0);
    check("a_rst_dout", a_dout, 0);
    rst_n = 1; a_dout_ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("a_no_stale", a_dout_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
